traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/light_channel_checker.sv | 70 +++++++
 rtl/traffic_light_monitor.sv | 100 ++++++++++
 tb/tb_traffic_light_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, direction indices and error codes for the
// traffic controller and its monitor.
package traffic_pkg;

   typedef enum logic [2:0] {
      RED    = 3'b100,
      YELLOW = 3'b010,
      GREEN  = 3'b001
   } light_e;

   localparam int NUM_DIR = 4;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_S = 2'd1,
      DIR_E = 2'd2,
      DIR_W = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ERR_ENC      = 2'd0,
      ERR_CONFLICT = 2'd1,
      ERR_SEQ      = 2'd2,
      ERR_TIMING   = 2'd3
   } err_code_e;

   function automatic logic [2:0] count4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [1:0] lowest4(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/light_channel_checker.sv
// Per-direction checker: tracks last valid light and its duration, and flags
// encoding, sequence and timing violations for the current sample.
module light_channel_checker
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN     = 8,
   parameter int YELLOW_CYCLES = 3,
   parameter int CW            = 8
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic [2:0] lights,
   output logic       enc_err,
   output logic       seq_err,
   output logic       tim_err,
   output logic       non_red,
   output logic       r2g
);

   localparam logic [CW-1:0] DUR_MAX   = '1;
   localparam logic [CW-1:0] MIN_G     = CW'(MIN_GREEN);
   localparam logic [CW-1:0] YEL_EXACT = CW'(YELLOW_CYCLES);

   light_e          last_valid_q, last_valid_d;
   logic [CW-1:0]   dur_q, dur_d;
   logic            valid;
   logic            g2y, y2r;

   assign valid = $onehot(lights);

   always_comb begin
      last_valid_d = last_valid_q;
      dur_d        = dur_q;
      enc_err      = 1'b0;
      seq_err      = 1'b0;
      tim_err      = 1'b0;
      non_red      = 1'b0;
      r2g          = 1'b0;
      g2y          = 1'b0;
      y2r          = 1'b0;
      if (!valid) begin
         // Bad sample: state frozen so the next good sample is judged against history.
         enc_err = 1'b1;
      end else begin
         non_red = (lights != RED);
         if (lights == last_valid_q) begin
            if (dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
         end else begin
            g2y          = (last_valid_q == GREEN)  && (lights == YELLOW);
            y2r          = (last_valid_q == YELLOW) && (lights == RED);
            r2g          = (last_valid_q == RED)    && (lights == GREEN);
            seq_err      = !(g2y || y2r || r2g);
            tim_err      = (g2y && (dur_q < MIN_G)) || (y2r && (dur_q != YEL_EXACT));
            dur_d        = CW'(1);
            last_valid_d = light_e'(lights);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_a) begin
         last_valid_q <= RED;
         dur_q        <= '0;
      end else begin
         last_valid_q <= last_valid_d;
         dur_q        <= dur_d;
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches the four light outputs of traffic_control and reports the
// highest-priority violation each cycle, plus sticky flags and a phase count.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN     = 8,
   parameter int YELLOW_CYCLES = 3,
   parameter int CW            = 8
) (
   input  logic        clk,
   input  logic        rst_a,
   input  logic [2:0]  n_lights,
   input  logic [2:0]  s_lights,
   input  logic [2:0]  e_lights,
   input  logic [2:0]  w_lights,
   output logic        err_pulse,
   output logic [1:0]  err_code,
   output logic [1:0]  err_dir,
   output logic [3:0]  err_sticky,
   output logic [15:0] phase_count
);

   logic [2:0] lights_all [NUM_DIR];
   logic [3:0] enc_v, seq_v, tim_v, non_red_v, r2g_v;

   assign lights_all[DIR_N] = n_lights;
   assign lights_all[DIR_S] = s_lights;
   assign lights_all[DIR_E] = e_lights;
   assign lights_all[DIR_W] = w_lights;

   for (genvar d = 0; d < NUM_DIR; d++) begin : g_chan
      light_channel_checker #(
         .MIN_GREEN     (MIN_GREEN),
         .YELLOW_CYCLES (YELLOW_CYCLES),
         .CW            (CW)
      ) u_chk (
         .clk     (clk),
         .rst_a   (rst_a),
         .lights  (lights_all[d]),
         .enc_err (enc_v[d]),
         .seq_err (seq_v[d]),
         .tim_err (tim_v[d]),
         .non_red (non_red_v[d]),
         .r2g     (r2g_v[d])
      );
   end

   logic        conflict;
   logic        err_pulse_q, err_pulse_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [1:0]  err_dir_q, err_dir_d;
   logic [3:0]  err_sticky_q, err_sticky_d;
   logic [15:0] phase_count_q, phase_count_d;

   always_comb begin
      conflict      = (count4(non_red_v) > 3'd1);
      err_pulse_d   = (|enc_v) || conflict || (|seq_v) || (|tim_v);
      err_code_d    = 2'd0;
      err_dir_d     = 2'd0;
      if (|enc_v) begin
         err_code_d = ERR_ENC;
         err_dir_d  = lowest4(enc_v);
      end else if (conflict) begin
         err_code_d = ERR_CONFLICT;
         err_dir_d  = lowest4(non_red_v);
      end else if (|seq_v) begin
         err_code_d = ERR_SEQ;
         err_dir_d  = lowest4(seq_v);
      end else if (|tim_v) begin
         err_code_d = ERR_TIMING;
         err_dir_d  = lowest4(tim_v);
      end
      // Sticky bit index matches err_code.
      err_sticky_d  = err_sticky_q | {(|tim_v), (|seq_v), conflict, (|enc_v)};
      phase_count_d = phase_count_q + 16'(count4(r2g_v));
   end

   always_ff @(posedge clk) begin
      if (rst_a) begin
         err_pulse_q   <= 1'b0;
         err_code_q    <= 2'd0;
         err_dir_q     <= 2'd0;
         err_sticky_q  <= 4'd0;
         phase_count_q <= 16'd0;
      end else begin
         err_pulse_q   <= err_pulse_d;
         err_code_q    <= err_code_d;
         err_dir_q     <= err_dir_d;
         err_sticky_q  <= err_sticky_d;
         phase_count_q <= phase_count_d;
      end
   end

   assign err_pulse   = err_pulse_q;
   assign err_code    = err_code_q;
   assign err_dir     = err_dir_q;
   assign err_sticky  = err_sticky_q;
   assign phase_count = phase_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scenario bench for traffic_light_monitor: expected error strobes are queued
// as each sample is driven and compared once the DUT has registered them.
module tb_traffic_light_monitor;
   import traffic_pkg::*;

   localparam logic [2:0] R   = 3'b100;
   localparam logic [2:0] Y   = 3'b010;
   localparam logic [2:0] G   = 3'b001;
   localparam logic [2:0] BAD = 3'b011;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1;
   logic [2:0]  n_lights = R, s_lights = R, e_lights = R, w_lights = R;
   logic        err_pulse;
   logic [1:0]  err_code, err_dir;
   logic [3:0]  err_sticky;
   logic [15:0] phase_count;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       pulse;
      logic [1:0] code;
      logic [1:0] dir;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   ev_t e, o;

   traffic_light_monitor #(
      .MIN_GREEN     (8),
      .YELLOW_CYCLES (3),
      .CW            (8)
   ) dut (
      .clk         (clk),
      .rst_a       (rst_a),
      .n_lights    (n_lights),
      .s_lights    (s_lights),
      .e_lights    (e_lights),
      .w_lights    (w_lights),
      .err_pulse   (err_pulse),
      .err_code    (err_code),
      .err_dir     (err_dir),
      .err_sticky  (err_sticky),
      .phase_count (phase_count)
   );

   always #5 clk = ~clk;

   task automatic apply(input logic [2:0] n, input logic [2:0] s, input logic [2:0] ea,
                        input logic [2:0] w, input logic ep = 1'b0,
                        input logic [1:0] ec = 2'd0, input logic [1:0] ed = 2'd0);
      n_lights = n; s_lights = s; e_lights = ea; w_lights = w;
      exp_q.push_back(ev_t'{ep, ec, ed});
      @(posedge clk);
      #1;
      obs_q.push_back(ev_t'{err_pulse, err_code, err_dir});
   endtask

   task automatic apply_run(input logic [2:0] n, input logic [2:0] s, input logic [2:0] ea,
                            input logic [2:0] w, input int cnt);
      for (int i = 0; i < cnt; i++) apply(n, s, ea, w);
   endtask

   task automatic do_reset();
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      n_lights = BAD; s_lights = BAD; e_lights = G; w_lights = G;
      rst_a = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({err_pulse, err_code, err_dir, err_sticky, phase_count} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pulse=%0b code=%0d dir=%0d sticky=%b phase=%0d, want all zero",
                     err_pulse, err_code, err_dir, err_sticky, phase_count);
         end
      end
      rst_a = 1'b0;
      apply(R, R, R, R);
      apply(R, R, R, R);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL reset_idle: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
   endtask

   task automatic test_nominal_phase();
      do_reset();
      apply_run(G, R, R, R, 8);
      apply_run(Y, R, R, R, 3);
      apply_run(R, R, R, R, 2);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL nominal: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
      checks++;
      if (phase_count !== 16'd1 || err_sticky !== 4'b0000) begin
         errors++;
         $display("FAIL nominal_counts: got phase=%0d sticky=%b, want phase=1 sticky=0000", phase_count, err_sticky);
      end
   endtask

   task automatic test_short_green();
      do_reset();
      apply_run(G, R, R, R, 5);
      apply(Y, R, R, R, 1'b1, 2'd3, 2'd0);
      apply_run(Y, R, R, R, 2);
      apply(R, R, R, R);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL short_green: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
      checks++;
      if (err_sticky !== 4'b1000) begin
         errors++;
         $display("FAIL short_green_sticky: got %b, want 1000", err_sticky);
      end
   endtask

   task automatic test_timing_bounds();
      do_reset();
      apply_run(G, R, R, R, 7);
      apply(Y, R, R, R, 1'b1, 2'd3, 2'd0);
      apply(Y, R, R, R);
      apply(R, R, R, R, 1'b1, 2'd3, 2'd0);
      apply_run(R, G, R, R, 8);
      apply_run(R, Y, R, R, 4);
      apply(R, R, R, R, 1'b1, 2'd3, 2'd1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL timing_bounds: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
      checks++;
      if (phase_count !== 16'd2) begin
         errors++;
         $display("FAIL timing_bounds_phase: got %0d, want 2", phase_count);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      apply_run(R, R, R, G, 260);
      apply_run(R, R, R, Y, 3);
      apply(R, R, R, R);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL saturation: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
   endtask

   task automatic test_sequence();
      do_reset();
      apply_run(R, R, G, R, 8);
      apply(R, R, R, R, 1'b1, 2'd2, 2'd2);
      apply(Y, R, R, R, 1'b1, 2'd2, 2'd0);
      apply(R, R, R, R, 1'b1, 2'd3, 2'd0);
      apply(R, R, R, R);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL sequence: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
      checks++;
      if (err_sticky !== 4'b1100) begin
         errors++;
         $display("FAIL sequence_sticky: got %b, want 1100", err_sticky);
      end
   endtask

   task automatic test_conflict();
      do_reset();
      apply(R, G, R, Y, 1'b1, 2'd1, 2'd1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL conflict: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
      checks++;
      if (err_sticky !== 4'b0110) begin
         errors++;
         $display("FAIL conflict_sticky: got %b, want 0110", err_sticky);
      end
   endtask

   task automatic test_priority();
      do_reset();
      apply(BAD, R, G, G, 1'b1, 2'd0, 2'd0);
      checks++;
      if (err_sticky !== 4'b0011 || phase_count !== 16'd2) begin
         errors++;
         $display("FAIL priority_state: got sticky=%b phase=%0d, want sticky=0011 phase=2", err_sticky, phase_count);
      end
      apply(R, R, R, R, 1'b1, 2'd2, 2'd2);
      apply(R, R, R, R);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL priority: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
   endtask

   task automatic test_reset_mid_phase();
      do_reset();
      apply(R, BAD, R, R, 1'b1, 2'd0, 2'd1);
      apply_run(G, R, R, R, 10);
      checks++;
      if (phase_count !== 16'd1 || err_sticky !== 4'b0001) begin
         errors++;
         $display("FAIL mid_reset_pre: got phase=%0d sticky=%b, want phase=1 sticky=0001", phase_count, err_sticky);
      end
      do_reset();
      checks++;
      if ({err_pulse, err_code, err_dir, err_sticky, phase_count} !== 25'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got pulse=%0b code=%0d dir=%0d sticky=%b phase=%0d, want all zero",
                  err_pulse, err_code, err_dir, err_sticky, phase_count);
      end
      apply(G, R, R, R);
      checks++;
      if (phase_count !== 16'd1) begin
         errors++;
         $display("FAIL mid_reset_phase: got %0d, want 1", phase_count);
      end
      apply_run(G, R, R, R, 2);
      apply(Y, R, R, R, 1'b1, 2'd3, 2'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.pulse !== e.pulse || (e.pulse && {o.code, o.dir} !== {e.code, e.dir})) begin
            errors++;
            $display("FAIL mid_reset: got pulse=%0b code=%0d dir=%0d, want pulse=%0b code=%0d dir=%0d",
                     o.pulse, o.code, o.dir, e.pulse, e.code, e.dir);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal_phase();
      test_short_green();
      test_timing_bounds();
      test_saturation();
      test_sequence();
      test_conflict();
      test_priority();
      test_reset_mid_phase();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
